uart_tx_arbiter: RTL and testbench

Shares the single UART transmit channel of `uart_controller` between `NUM_REQ` byte sources. It arbitrates round-robin, latches the winning byte, and drives the TX handshake (`i_Tx_Byte`/`i_Tx_Ready` in, `o_Tx_Active`/`o_Tx_Done` out of the TX side). It then holds off further grants until the current byte has left the line. It sits between the requester logic and `uart_controller`, in the system clock domain.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART TX arbiter
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_e;

  localparam logic [7:0] TX_BYTE_RST = 8'h00;
  localparam int         NUM_REQ_MIN = 1;
  localparam int         NUM_REQ_MAX = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker
// Scans from i_start upward with wrap-around and reports the first set request.
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic [N-1:0] o_onehot,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!o_valid && i_req[(int'(i_start) + off) % N]) begin
        o_onehot[(int'(i_start) + off) % N] = 1'b1;
        o_idx   = W'((int'(i_start) + off) % N);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART TX channel
// Optional owner lock for packet atomicity under UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   i_Req_Lock,
`endif
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic [7:0]           o_Tx_Byte,
  output logic                 o_Tx_Ready,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic [OWNER_W-1:0]   o_Owner
);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_range_chk
    $error("uart_tx_arbiter: NUM_REQ out of range");
  end

  arb_state_e           r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [7:0]           r_tx_byte, w_tx_byte_nxt;
  logic [OWNER_W-1:0]   r_owner, w_owner_nxt;
  logic                 r_tx_ready, w_tx_ready_nxt;
  logic                 r_busy;

  logic [OWNER_W-1:0]   w_start;
  logic [NUM_REQ-1:0]   w_pick_onehot, w_sel_onehot;
  logic [OWNER_W-1:0]   w_pick_idx, w_sel_idx;
  logic                 w_pick_valid;
  logic                 w_lock_hit;

  assign w_start = (int'(r_owner) >= NUM_REQ - 1) ? '0 : OWNER_W'(r_owner + 1'b1);

  rr_priority_picker #(
    .N (NUM_REQ),
    .W (OWNER_W)
  ) u_picker (
    .i_req    (i_Req),
    .i_start  (w_start),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // A locked owner that is still requesting keeps the channel for its next byte.
`ifdef UART_TX_ARB_LOCK_EN
  assign w_lock_hit = i_Req_Lock[r_owner] & i_Req[r_owner];
`else
  assign w_lock_hit = 1'b0;
`endif

  assign w_sel_onehot = w_lock_hit ? (NUM_REQ'(1) << r_owner) : w_pick_onehot;
  assign w_sel_idx    = w_lock_hit ? r_owner : w_pick_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_tx_byte  <= TX_BYTE_RST;
      r_owner    <= OWNER_W'(NUM_REQ - 1);
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_owner    <= w_owner_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_busy     <= (w_state_nxt != ARB_IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = '0;
    w_tx_byte_nxt  = r_tx_byte;
    w_owner_nxt    = r_owner;
    w_tx_ready_nxt = r_tx_ready;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt    = w_sel_onehot;
          w_tx_byte_nxt  = i_Req_Byte[8*int'(w_sel_idx) +: 8];
          w_owner_nxt    = w_sel_idx;
          w_tx_ready_nxt = 1'b1;
          w_state_nxt    = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        // Done outranks Active so a short transfer can never strand us in BUSY.
        if (i_Tx_Done) begin
          w_tx_ready_nxt = 1'b0;
          w_state_nxt    = ARB_IDLE;
        end else if (i_Tx_Active) begin
          w_tx_ready_nxt = 1'b0;
          w_state_nxt    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        w_tx_ready_nxt = 1'b0;
        if (i_Tx_Done) w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_tx_ready_nxt = 1'b0;
        w_state_nxt    = ARB_IDLE;
      end
    endcase
  end

  assign o_Grant    = r_grant;
  assign o_Tx_Byte  = r_tx_byte;
  assign o_Tx_Ready = r_tx_ready;
  assign o_Busy     = r_busy;
  assign o_Owner    = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
// Lock expectations follow UART_TX_ARB_LOCK_EN when it is defined.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  i_Req = '0;
  logic [31:0] i_Req_Byte = '0;
  logic [3:0]  i_Req_Lock = '0;
  logic [3:0]  o_Grant;
  logic [7:0]  o_Tx_Byte;
  logic        o_Tx_Ready;
  logic        i_Tx_Active = 1'b0;
  logic        i_Tx_Done = 1'b0;
  logic        o_Busy;
  logic [1:0]  o_Owner;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_Req       (i_Req),
    .i_Req_Byte  (i_Req_Byte),
`ifdef UART_TX_ARB_LOCK_EN
    .i_Req_Lock  (i_Req_Lock),
`endif
    .o_Grant     (o_Grant),
    .o_Tx_Byte   (o_Tx_Byte),
    .o_Tx_Ready  (o_Tx_Ready),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done),
    .o_Busy      (o_Busy),
    .o_Owner     (o_Owner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_grant(output logic [3:0] g, output int cyc);
    g   = '0;
    cyc = 0;
    while (g == 4'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      g = o_Grant;
    end
    if (g == 4'b0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic xfer();
    i_Tx_Active = 1'b1;
    @(negedge clk);
    i_Tx_Active = 1'b0;
    i_Tx_Done   = 1'b1;
    @(negedge clk);
    i_Tx_Done   = 1'b0;
  endtask

  logic [3:0] g;
  int         cyc;
  int         exp_fair [5] = '{0, 1, 2, 3, 0};
`ifdef UART_TX_ARB_LOCK_EN
  int         exp_lock [4] = '{1, 1, 1, 2};
`else
  int         exp_lock [4] = '{1, 2, 1, 2};
`endif

  initial begin
    // reset values
    @(negedge clk);
    check("rst_grant", o_Grant, 0);
    check("rst_ready", o_Tx_Ready, 0);
    check("rst_byte", o_Tx_Byte, 0);
    check("rst_busy", o_Busy, 0);
    check("rst_owner", o_Owner, 3);
    do_reset();

    // single request
    i_Req_Byte = 32'h00A5_0000;
    i_Req      = 4'b0100;
    wait_grant(g, cyc);
    check("single_lat", cyc, 1);
    check("single_grant", g, 4'b0100);
    check("single_ready", o_Tx_Ready, 1);
    check("single_byte", o_Tx_Byte, 8'hA5);
    check("single_owner", o_Owner, 2);
    check("single_busy", o_Busy, 1);
    i_Req = 4'b0;
    @(negedge clk);
    check("single_pulse", o_Grant, 0);
    check("single_hold", o_Tx_Ready, 1);
    xfer();
    check("single_idle", o_Busy, 0);

    // fairness
    do_reset();
    i_Req_Byte = 32'h1312_1110;
    i_Req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g, cyc);
      check("fair_grant", g, 32'd1 << exp_fair[i]);
      check("fair_byte", o_Tx_Byte, 32'h10 + exp_fair[i]);
      if (i > 0) check("fair_gap", cyc, 1);
      xfer();
    end

    // wrap-around
    i_Req = 4'b1000;
    wait_grant(g, cyc);
    check("wrap_pre", g, 4'b1000);
    i_Req = 4'b1001;
    xfer();
    wait_grant(g, cyc);
    check("wrap_grant", g, 4'b0001);
    i_Req = 4'b0;
    xfer();

    // Done with no Active
    i_Req = 4'b0010;
    wait_grant(g, cyc);
    check("dna_grant", g, 4'b0010);
    i_Req     = 4'b0;
    i_Tx_Done = 1'b1;
    @(negedge clk);
    i_Tx_Done = 1'b0;
    check("dna_busy", o_Busy, 0);
    check("dna_ready", o_Tx_Ready, 0);

    // Done and Active together
    i_Req = 4'b0100;
    wait_grant(g, cyc);
    check("both_grant", g, 4'b0100);
    i_Req       = 4'b0;
    i_Tx_Active = 1'b1;
    i_Tx_Done   = 1'b1;
    @(negedge clk);
    i_Tx_Active = 1'b0;
    i_Tx_Done   = 1'b0;
    check("both_busy", o_Busy, 0);
    @(negedge clk);
    check("both_stay", o_Busy, 0);

    // reset in BUSY
    i_Req = 4'b1000;
    wait_grant(g, cyc);
    i_Req       = 4'b0;
    i_Tx_Active = 1'b1;
    @(negedge clk);
    check("mid_busy", o_Busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", o_Busy, 0);
    check("mid_rst_ready", o_Tx_Ready, 0);
    check("mid_rst_byte", o_Tx_Byte, 0);
    check("mid_rst_owner", o_Owner, 3);
    i_Tx_Active = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    i_Req   = 4'b0101;
    wait_grant(g, cyc);
    check("mid_first", g, 4'b0001);
    check("mid_byte", o_Tx_Byte, 8'h10);
    i_Req = 4'b0100;
    xfer();
    wait_grant(g, cyc);
    check("mid_second", g, 4'b0100);
    i_Req = 4'b0;
    xfer();

    // lock
    do_reset();
    i_Req_Lock = 4'b0010;
    i_Req      = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g, cyc);
      check("lock_order", g, 32'd1 << exp_lock[i]);
`ifdef UART_TX_ARB_LOCK_EN
      if (i == 2) begin
        i_Req      = 4'b0100;
        i_Req_Lock = 4'b0;
      end
`endif
      xfer();
    end
    i_Req = 4'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
